// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU stage: opcodes, FSM state encoding, flag bit positions.
package alu_stage_pkg;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_INC  = 4'd9;
  localparam logic [3:0] OP_DEC  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // flags bus is {Z,N,C,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done is asserted during the last iteration; product then presents the final
// (combinational) accumulator value so the caller can capture it on that edge.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  // next accumulator: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
  end

  assign done    = run && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  // iteration registers: load on start, then shift one bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_stage.sv
// Single-issue ALU stage with registered result and {Z,N,C,V} flags.
// Optional multiplier: define ALU_MUL_EN to add the MUL state and op 11;
// without it op 11 behaves as a NOP.
module alu_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rin,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             accept, load;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   ext;
  logic             c, v, wr;

  assign accept = (state == S_IDLE) && start;
  assign busy   = (state == S_EXEC) || (state == S_MUL);
  assign done   = (state == S_DONE);
  assign load   = (state_nxt == S_DONE);

`ifdef ALU_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  // multiplier takes the bus operands directly on the accepting edge
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && (op == OP_MUL)),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );
`endif

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MUL_EN
          state_nxt = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
          state_nxt = S_EXEC;
`endif
        end
      end
      S_EXEC: state_nxt = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:  if (mul_done) state_nxt = S_DONE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // result and carry/overflow from the latched operands; wr=0 marks a NOP
  always_comb begin
    res = rin;
    ext = '0;
    c   = 1'b0;
    v   = 1'b0;
    wr  = 1'b1;
    case (op_q)
      OP_PASS: res = a_q;
      OP_ADD: begin
        ext = {1'b0, a_q} + {1'b0, b_q};
        res = ext[MSB:0];
        c   = ext[WIDTH];
        v   = (a_q[MSB] == b_q[MSB]) && (res[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        ext = {1'b0, a_q} - {1'b0, b_q};
        res = ext[MSB:0];
        c   = ext[WIDTH];
        v   = (a_q[MSB] != b_q[MSB]) && (res[MSB] != a_q[MSB]);
      end
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_NOT:  res = ~a_q;
      OP_SHL: begin
        res = {a_q[MSB-1:0], 1'b0};
        c   = a_q[MSB];
      end
      OP_SHR: begin
        res = {1'b0, a_q[MSB:1]};
        c   = a_q[0];
      end
      OP_INC: begin
        ext = {1'b0, a_q} + (WIDTH+1)'(1);
        res = ext[MSB:0];
        c   = ext[WIDTH];
        v   = !a_q[MSB] && res[MSB];
      end
      OP_DEC: begin
        ext = {1'b0, a_q} - (WIDTH+1)'(1);
        res = ext[MSB:0];
        c   = ext[WIDTH];
        v   = a_q[MSB] && !res[MSB];
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        res = mul_prod[MSB:0];
        c   = |mul_prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: wr = 1'b0;
    endcase
  end

  // state, operand latch, and result/flag capture on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      rin   <= '0;
      flags <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      if (load && wr) begin
        rin           <= res;
        flags[FLAG_Z] <= (res == '0);
        flags[FLAG_N] <= res[MSB];
        flags[FLAG_C] <= c;
        flags[FLAG_V] <= v;
      end
    end
  end

endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 Parameter: WIDTH, 8, datapath width of operands, result and register-file buses.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 START  input  1  request pulse; operands and opcode sampled when START=1 in IDLE.
REQ-006 OP  input  4  opcode (encoding per REQ-012).
REQ-007 A  input  WIDTH  operand A, driven from register-file bus A.
REQ-008 B  input  WIDTH  operand B, driven from register-file bus B.
REQ-009 BUSY  output  1  high while an operation is in progress (EXEC or MUL state).
REQ-010 DONE  output  1  one-cycle pulse when RIN and FLAGS are valid.
REQ-011 RIN  output  WIDTH  registered result; feeds register-file write data. FLAGS  output  4  registered {Z,N,C,V}.

Function
REQ-012 Opcodes: 0 PASS A, 1 ADD, 2 SUB (A-B), 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 SHL A, 8 SHR A (logical), 9 INC A, 10 DEC A, 11 MUL; 12-15 NOP.
REQ-013 FSM states IDLE, EXEC, MUL, DONE; IDLE->EXEC on START with non-MUL op, IDLE->MUL on START with op 11, EXEC->DONE after one cycle, MUL->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-014 A, B, OP latched into internal operand registers on the accepting edge; later bus changes have no effect on the running operation.
REQ-015 Non-MUL latency: DONE asserted exactly 2 cycles after the START-accepting edge.
REQ-016 MUL: shift-add, one partial product per cycle; RIN = low WIDTH bits of A*B; DONE asserted WIDTH+1 cycles after accept.
REQ-017 START while BUSY=1 or in DONE state is ignored and not queued.
REQ-018 RIN and FLAGS update only on the edge entering DONE; held stable otherwise.
REQ-019 Z = (RIN==0); N = RIN[WIDTH-1] for all non-NOP ops.
REQ-020 C: ADD/INC carry-out; SUB/DEC borrow (1 when A<B or A==0); SHL = A[WIDTH-1]; SHR = A[0]; MUL = (high half of product != 0); logic/PASS/NOT clear C.
REQ-021 V: signed overflow for ADD/SUB/INC/DEC; cleared for all other non-NOP ops.
REQ-022 Arithmetic wraps modulo 2^WIDTH (0xFF+1 -> 0x00, C=1).
REQ-023 NOP: RIN and FLAGS unchanged, DONE still pulses with standard latency.

Reset
REQ-024 RST_N low: state IDLE, RIN=0, FLAGS=0, BUSY=0, DONE=0, operand registers and multiplier accumulator cleared, immediately and independent of CLK.
REQ-025 Reset mid-operation aborts it; no DONE pulse is produced for the aborted request.
REQ-026 First START is accepted on the first rising edge after RST_N deasserts.

Configuration
REQ-027 Macro ALU_MUL_EN: defined -> MUL state, shift-add datapath and op 11 present per REQ-016.
REQ-028 ALU_MUL_EN undefined -> no MUL state or datapath; op 11 decodes as NOP (REQ-023, 2-cycle latency).

Structure
REQ-029 Shared package holds opcode constants, FSM state encoding and flag bit indices (Z=3, N=2, C=1, V=0).
REQ-030 One sub-module, alu_mul_seq, contains the iterative multiplier (start, operands, done, product), instantiated only under ALU_MUL_EN.

Verification
REQ-031 ADD A=0x7F B=0x01 -> RIN=0x80, FLAGS N=1 V=1 C=0 Z=0, DONE 2 cycles after accept.
REQ-032 SUB A=0x00 B=0x01 -> RIN=0xFF, C=1 N=1; INC A=0xFF -> RIN=0x00, Z=1 C=1.
REQ-033 MUL A=0x10 B=0x11 -> RIN=0x10, C=1, DONE at cycle 9, BUSY high cycles 1-8; second START at cycle 3 ignored.
REQ-034 SHL A=0x81 -> RIN=0x02 C=1; SHR A=0x81 -> RIN=0x40 C=1; op 13 -> RIN/FLAGS unchanged, DONE pulses.
REQ-035 RST_N pulsed low during MUL cycle 4 -> RIN=0, FLAGS=0, IDLE, no DONE; next ADD 0x02+0x03 -> 0x05.
REQ-036 Build without ALU_MUL_EN: op 11 A=0x03 B=0x04 -> RIN unchanged, DONE 2 cycles after accept.
